pwm_multi: RTL and testbench
============================

PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter CH, default 4, number of PWM channels (1..16).
REQ-002 SHALL have parameter CW, default 8, counter/duty/period width in bits (2..16).
REQ-003 SHALL have port clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  run enable; low holds the counter and forces outputs low.
REQ-006 SHALL have port load  input  1  single-cycle strobe; captures period, duty and dir_in into staging.
REQ-007 SHALL have port period  input  CW  last count of the PWM period (period length = period+1 cycles).
REQ-008 SHALL have port duty  input  CH*CW  per-channel high-time in cycles; channel i uses bits [i*CW +: CW].
REQ-009 SHALL have port dir_in  input  CH  per-channel motor direction request.
REQ-010 SHALL have port pwm_out  output  CH  registered PWM outputs.
REQ-011 SHALL have port dir_out  output  CH  registered applied direction.
REQ-012 SHALL have port period_end  output  1  registered one-cycle pulse marking the last cycle of each period.
REQ-013 SHALL have port pending  output  1  high while staged values await application.

Function
REQ-014 Counter cnt SHALL count 0..period_act and wrap to 0 when en=1; it SHALL be held at 0 while en=0.
REQ-015 Boundary SHALL be the cycle with en=1 and cnt==period_act; period_end SHALL be high in the cycle after the boundary, for exactly one cycle.
REQ-016 pwm_out[i] SHALL be high in the cycle after cnt takes value c iff en=1, blank[i]=0 and c < duty_act[i] (1-cycle registered latency).
REQ-017 duty_act[i]=0 SHALL give constant low; duty_act[i] > period_act SHALL give constant high (100 %).
REQ-018 period_act=0 SHALL give a boundary every cycle; the output is high iff duty_act[i] >= 1.
REQ-019 load=1 SHALL copy period, duty and dir_in into staging and set pending=1 on the next edge.
REQ-020 A load while pending=1 SHALL overwrite staging; only the latest load is applied.
REQ-021 At a boundary with pending=1, active SHALL be set from staging, pending SHALL be cleared and cnt SHALL restart at 0 with the new period.
REQ-022 A load in the boundary cycle SHALL NOT be applied at that boundary; it SHALL be captured and applied at the following boundary.
REQ-023 When en=0 and pending=1, staging SHALL be applied on the next edge (no boundary wait).
REQ-024 When an applied dir bit differs from the previous dir_out[i], blank[i] SHALL be set; pwm_out[i] SHALL be low for the entire following period; blank[i] SHALL clear at the next boundary.
REQ-025 dir_out SHALL change only when staging is applied.
REQ-026 Falling en SHALL force all pwm_out low on the next edge. Rising en SHALL start at cnt=0, and the first high output SHALL appear one cycle later.
REQ-027 Comparisons SHALL be unsigned, CW bits wide, with no truncation or overflow of cnt.

Reset
REQ-028 While rst_n=0: cnt=0, period_act=all ones, duty_act=0, staging=0, blank=0, pending=0, pwm_out=0, dir_out=0, period_end=0.
REQ-029 Reset asserted mid-period or with pending=1 SHALL discard staging immediately; no partial pulse SHALL follow release.

Structure
REQ-030 A shared package pwm_pkg SHALL hold the default CH/CW constants and the staging-record typedef (period, duty array, dir).
REQ-031 Per-channel compare/blank logic SHALL be one sub-module pwm_chan, instantiated CH times by a generate loop; the counter, staging and pending logic SHALL stay in pwm_multi.

Verification
REQ-032 CW=8, load period=9, duty0=3, en=1 -> after application, pwm_out[0] repeats 3 high / 7 low; period_end every 10 cycles.
REQ-033 duty0=0, duty1=10, period=9 -> pwm_out[0] constant 0, pwm_out[1] constant 1.
REQ-034 Mid-period, load duty0=7 then load duty0=5 -> pending=1 until the boundary, then duty 5 applies and duty 7 is never seen.
REQ-035 Load dir_in[2]=1, was 0, duty2=4 -> dir_out[2] rises at the boundary; pwm_out[2] stays low for 10 cycles, then resumes 4 high / 6 low.
REQ-036 Load in the boundary cycle; separately, en=0 with pending -> first case applies one period later; second case applies on the next edge.
REQ-037 Assert rst_n=0 at cnt=5 with pending=1 -> all outputs 0 asynchronously; after release, pending=0 and outputs stay low until a new load.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and the staging-record type for the multi-channel PWM block.
// The record is sized for the largest legal configuration; unused upper bits stay zero.
package pwm_pkg;

  localparam int CH_DEF = 4;
  localparam int CW_DEF = 8;
  localparam int CH_MAX = 16;
  localparam int CW_MAX = 16;

  typedef struct packed {
    logic [CW_MAX-1:0]             period;
    logic [CH_MAX-1:0][CW_MAX-1:0] duty;
    logic [CH_MAX-1:0]             dir;
  } pwm_stage_t;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: active duty register, direction-change blanking and the
// registered compare output against the shared period counter.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [CW-1:0] cnt,
  input  logic          boundary,
  input  logic          apply,
  input  logic [CW-1:0] duty_new,
  input  logic          dir_change,
  output logic          pwm_out
);

  logic [CW-1:0] duty_act;
  logic          blank;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset branch is asynchronous and comes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act <= '0;
      blank    <= 1'b0;
      pwm_out  <= 1'b0;
    end else begin
      // Compare uses the duty/blank in force during the current count value.
      pwm_out <= en && !blank && (cnt < duty_act);
      if (apply) begin
        duty_act <= duty_new;
      end
      // A reversal silences the channel for one full period after it is applied.
      if (apply && dir_change) begin
        blank <= 1'b1;
      end else if (boundary) begin
        blank <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared period counter, double-buffered settings that
// take effect at period boundaries, and per-channel direction-change blanking.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int CW = CW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CW-1:0]    period,
  input  logic [CH*CW-1:0] duty,
  input  logic [CH-1:0]    dir_in,
  output logic [CH-1:0]    pwm_out,
  output logic [CH-1:0]    dir_out,
  output logic             period_end,
  output logic             pending
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] period_act;
  pwm_stage_t    stage;
  pwm_stage_t    stage_in;
  logic          boundary;
  logic          apply;
  logic [CH-1:0] dir_new;
  logic [CH-1:0] dir_change;

  assign boundary   = en && (cnt == period_act);
  // While stopped there is no boundary to wait for, so staged values go in at once.
  assign apply      = pending && (boundary || !en);
  assign dir_new    = stage.dir[CH-1:0];
  assign dir_change = dir_new ^ dir_out;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    stage_in = '0;
    stage_in.period[CW-1:0] = period;
    for (int i = 0; i < CH; i++) begin
      stage_in.duty[i][CW-1:0] = duty[i*CW +: CW];
    end
    stage_in.dir[CH-1:0] = dir_in;
  end

  // A load always wins over a simultaneous apply: the new values wait for the next boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage   <= '0;
      pending <= 1'b0;
    end else if (load) begin
      stage   <= stage_in;
      pending <= 1'b1;
    end else if (apply) begin
      pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      period_act <= '1;
      dir_out    <= '0;
      period_end <= 1'b0;
    end else begin
      period_end <= boundary;
      if (!en || boundary) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (apply) begin
        period_act <= stage.period[CW-1:0];
        dir_out    <= dir_new;
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    pwm_chan #(
      .CW(CW)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .cnt       (cnt),
      .boundary  (boundary),
      .apply     (apply),
      .duty_new  (stage.duty[g][CW-1:0]),
      .dir_change(dir_change[g]),
      .pwm_out   (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: each task drives one scenario and checks
// outputs one time unit after each rising edge against hand-derived values.
module tb_pwm_multi;

  localparam int CH = 4;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             load;
  logic [CW-1:0]    period;
  logic [CH*CW-1:0] duty;
  logic [CH-1:0]    dir_in;
  logic [CH-1:0]    pwm_out;
  logic [CH-1:0]    dir_out;
  logic             period_end;
  logic             pending;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pwm_multi #(.CH(CH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .period    (period),
    .duty      (duty),
    .dir_in    (dir_in),
    .pwm_out   (pwm_out),
    .dir_out   (dir_out),
    .period_end(period_end),
    .pending   (pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_duty(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    duty = {d3, d2, d1, d0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; load = 1'b0; period = '0; duty = '0; dir_in = '0;
    #12;
    n_cmp++;
    if ({pwm_out, dir_out} !== 8'h00) begin
      n_bad++; $display("FAIL reset_outs: got %b want 00000000", {pwm_out, dir_out});
    end
    n_cmp++;
    if ({period_end, pending} !== 2'b00) begin
      n_bad++; $display("FAIL reset_flags: got %b want 00", {period_end, pending});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // period 9, duties 3/10/0/9: applied while stopped, then two full periods.
  task automatic test_basic();
    logic [3:0] exp_pwm;
    period = 8'd9; set_duty(3, 10, 0, 9); dir_in = 4'b0000; load = 1'b1;
    step(); load = 1'b0;
    n_cmp++;
    if (pending !== 1'b1) begin
      n_bad++; $display("FAIL basic_pending_set: got %b want 1", pending);
    end
    step();
    n_cmp++;
    if (pending !== 1'b0) begin
      n_bad++; $display("FAIL basic_pending_clr: got %b want 0", pending);
    end
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      int c;
      c = k % 10;
      step();
      exp_pwm = {(c < 9), 1'b0, 1'b1, (c < 3)};
      n_cmp++;
      if (pwm_out !== exp_pwm) begin
        n_bad++; $display("FAIL basic_pwm c=%0d: got %b want %b", c, pwm_out, exp_pwm);
      end
      n_cmp++;
      if (period_end !== (c == 9)) begin
        n_bad++; $display("FAIL basic_pend c=%0d: got %b want %b", c, period_end, (c == 9));
      end
    end
  endtask

  // Two loads mid-period: only the second (duty0=5) is ever applied.
  task automatic test_double_load();
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (pwm_out[0] !== 1'b1) begin
        n_bad++; $display("FAIL dbl_pre c=%0d: got %b want 1", c, pwm_out[0]);
      end
    end
    set_duty(7, 10, 0, 9); load = 1'b1;
    step();
    set_duty(5, 10, 0, 9);
    step(); load = 1'b0;
    n_cmp++;
    if (pending !== 1'b1) begin
      n_bad++; $display("FAIL dbl_pending: got %b want 1", pending);
    end
    for (int c = 5; c < 10; c++) begin
      step();
      n_cmp++;
      if (pwm_out[0] !== 1'b0) begin
        n_bad++; $display("FAIL dbl_wait_pwm c=%0d: got %b want 0", c, pwm_out[0]);
      end
      n_cmp++;
      if ({period_end, pending} !== ((c == 9) ? 2'b10 : 2'b01)) begin
        n_bad++; $display("FAIL dbl_wait_flags c=%0d: got %b want %b", c,
                          {period_end, pending}, (c == 9) ? 2'b10 : 2'b01);
      end
    end
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if ({pwm_out[3], pwm_out[0]} !== {(c < 9), (c < 5)}) begin
        n_bad++; $display("FAIL dbl_new c=%0d: got %b want %b", c,
                          {pwm_out[3], pwm_out[0]}, {(c < 9), (c < 5)});
      end
    end
  endtask

  // Direction reversal on channel 2: one blank period, then 4 high / 6 low.
  task automatic test_dir_blank();
    set_duty(5, 10, 4, 9); dir_in = 4'b0100; load = 1'b1;
    step(); load = 1'b0;
    for (int c = 1; c < 10; c++) begin
      step();
      if (c == 8) begin
        n_cmp++;
        if (dir_out !== 4'b0000) begin
          n_bad++; $display("FAIL dir_early: got %b want 0000", dir_out);
        end
      end
    end
    n_cmp++;
    if ({dir_out, period_end} !== 5'b01001) begin
      n_bad++; $display("FAIL dir_apply: got %b want 01001", {dir_out, period_end});
    end
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if ({pwm_out[2], pwm_out[0]} !== {1'b0, (c < 5)}) begin
        n_bad++; $display("FAIL dir_blank c=%0d: got %b want %b", c,
                          {pwm_out[2], pwm_out[0]}, {1'b0, (c < 5)});
      end
    end
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if ({dir_out, pwm_out[2]} !== {4'b0100, (c < 4)}) begin
        n_bad++; $display("FAIL dir_resume c=%0d: got %b want %b", c,
                          {dir_out, pwm_out[2]}, {4'b0100, (c < 4)});
      end
    end
  endtask

  // Load during the boundary cycle is held for one more period.
  task automatic test_boundary_load();
    for (int c = 0; c < 9; c++) step();
    set_duty(2, 10, 4, 9); load = 1'b1;
    step(); load = 1'b0;
    n_cmp++;
    if ({period_end, pending} !== 2'b11) begin
      n_bad++; $display("FAIL bload_capture: got %b want 11", {period_end, pending});
    end
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if ({pending, pwm_out[0]} !== {(c != 9), (c < 5)}) begin
        n_bad++; $display("FAIL bload_old c=%0d: got %b want %b", c,
                          {pending, pwm_out[0]}, {(c != 9), (c < 5)});
      end
    end
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if (pwm_out[0] !== (c < 2)) begin
        n_bad++; $display("FAIL bload_new c=%0d: got %b want %b", c, pwm_out[0], (c < 2));
      end
    end
  endtask

  // Dropping en applies staging on the next edge and silences outputs; restart from cnt 0.
  task automatic test_en_low_apply();
    step(); step();
    set_duty(6, 10, 4, 9); load = 1'b1;
    step(); load = 1'b0;
    n_cmp++;
    if (pending !== 1'b1) begin
      n_bad++; $display("FAIL enlow_pending: got %b want 1", pending);
    end
    en = 1'b0;
    step();
    n_cmp++;
    if ({pwm_out, pending} !== 5'b00000) begin
      n_bad++; $display("FAIL enlow_apply: got %b want 00000", {pwm_out, pending});
    end
    step();
    n_cmp++;
    if ({pwm_out, period_end} !== 5'b00000) begin
      n_bad++; $display("FAIL enlow_hold: got %b want 00000", {pwm_out, period_end});
    end
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++;
      if ({period_end, pwm_out[2:0]} !== {(c == 9), (c < 4), 1'b1, (c < 6)}) begin
        n_bad++; $display("FAIL enlow_run c=%0d: got %b want %b", c, {period_end, pwm_out[2:0]},
                          {(c == 9), (c < 4), 1'b1, (c < 6)});
      end
    end
  endtask

  // period 0: boundary every cycle, output high iff duty >= 1.
  task automatic test_period_zero();
    en = 1'b0; period = 8'd0; set_duty(0, 1, 5, 0); load = 1'b1;
    step(); load = 1'b0;
    step();
    n_cmp++;
    if (pending !== 1'b0) begin
      n_bad++; $display("FAIL pz_apply: got %b want 0", pending);
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if ({period_end, pwm_out} !== 5'b10110) begin
        n_bad++; $display("FAIL pz_run k=%0d: got %b want 10110", k, {period_end, pwm_out});
      end
    end
  endtask

  // Asynchronous reset at cnt 5 with a load pending: everything clears, nothing resumes.
  task automatic test_reset_mid();
    en = 1'b0; period = 8'd9; set_duty(3, 10, 0, 0); load = 1'b1;
    step(); load = 1'b0;
    step();
    en = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_cmp++;
      if (pwm_out[1:0] !== {1'b1, (c < 3)}) begin
        n_bad++; $display("FAIL rmid_pre c=%0d: got %b want %b", c, pwm_out[1:0], {1'b1, (c < 3)});
      end
    end
    set_duty(8, 10, 0, 0); load = 1'b1;
    step(); load = 1'b0;
    n_cmp++;
    if ({pending, pwm_out[1], dir_out} !== 6'b110100) begin
      n_bad++; $display("FAIL rmid_armed: got %b want 110100", {pending, pwm_out[1], dir_out});
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({pwm_out, dir_out, period_end, pending} !== 10'b0) begin
      n_bad++; $display("FAIL rmid_async: got %b want 0000000000",
                        {pwm_out, dir_out, period_end, pending});
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      n_cmp++;
      if ({pwm_out, dir_out, period_end, pending} !== 10'b0) begin
        n_bad++; $display("FAIL rmid_after k=%0d: got %b want 0000000000", k,
                          {pwm_out, dir_out, period_end, pending});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_double_load();
    test_dir_blank();
    test_boundary_load();
    test_en_low_apply();
    test_period_zero();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
